// File: rtl/frame_bitrev_buffer.sv
// Ping-pong frame buffer between the window stage and the FFT.
// Samples are written in natural order and read back in bit-reversed order.
// There are two banks. One bank fills while the other drains.
// Samples that arrive while no bank is free are dropped and flagged on overflow.
module frame_bitrev_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow
);

  localparam int AW = $clog2(FRAME_SIZE);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rd_st_t;

  bank_st_t              bank_st [2];
  rd_st_t                rd_st;
  logic                  wr_bank, rd_bank, rd_other;
  logic [AW-1:0]         wr_idx, rd_cnt;
  logic [DATA_WIDTH-1:0] mem [2*FRAME_SIZE];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  out_valid_q, out_last_q, ovf_q;

  logic                  xfer, rel_bank, wr_free, wr_en, rd_load;
  logic [AW:0]           rd_addr;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  assign rd_other = ~rd_bank;
  assign xfer     = out_valid_q && out_ready;
  // The draining bank is handed back on its final transfer.
  // A sample that needs that bank in the same cycle is therefore not dropped.
  assign rel_bank = (rd_st == R_STREAM) && xfer && out_last_q;
  assign wr_free  = (bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING) ||
                    (rel_bank && (rd_bank == wr_bank));
  assign wr_en    = in_valid && wr_free;
  // The output register doubles as the RAM read register.
  // It is reloaded only when it is empty or when its current sample is consumed.
  // A stall therefore holds the sample without a separate skid stage.
  assign rd_load  = (rd_st == R_PRIME) || ((rd_st == R_STREAM) && xfer && !out_last_q);
  assign rd_addr  = {rd_bank, bitrev(rd_cnt)};

  assign out_data  = out_valid_q ? rd_q : '0;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = ovf_q;

  // Sample RAM: natural-order writes, bit-reversed registered reads
  always_ff @(posedge clk) begin
    if (wr_en)   mem[{wr_bank, wr_idx}] <= in_data;
    if (rd_load) rd_q <= mem[rd_addr];
  end

  // Bank bookkeeping, write pointer and read FSM; write updates win on a shared bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]  <= B_EMPTY;
      bank_st[1]  <= B_EMPTY;
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_bank     <= 1'b0;
      rd_cnt      <= '0;
      rd_st       <= R_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= in_valid && !wr_free;

      case (rd_st)
        R_IDLE: begin
          if (bank_st[rd_bank] == B_FULL) begin
            bank_st[rd_bank] <= B_DRAINING;
            rd_cnt           <= '0;
            rd_st            <= R_PRIME;
          end
        end
        R_PRIME: begin
          out_valid_q <= 1'b1;
          out_last_q  <= (rd_cnt == AW'(FRAME_SIZE - 1));
          rd_cnt      <= rd_cnt + 1'b1;
          rd_st       <= R_STREAM;
        end
        R_STREAM: begin
          if (xfer) begin
            if (out_last_q) begin
              out_valid_q      <= 1'b0;
              out_last_q       <= 1'b0;
              bank_st[rd_bank] <= B_EMPTY;
              rd_bank          <= rd_other;
              // Go straight to priming the other bank if it is already waiting.
              if (bank_st[rd_other] == B_FULL) begin
                bank_st[rd_other] <= B_DRAINING;
                rd_cnt            <= '0;
                rd_st             <= R_PRIME;
              end else begin
                rd_st <= R_IDLE;
              end
            end else begin
              out_last_q <= (rd_cnt == AW'(FRAME_SIZE - 1));
              rd_cnt     <= rd_cnt + 1'b1;
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase

      if (wr_en) begin
        if (wr_idx == AW'(FRAME_SIZE - 1)) begin
          bank_st[wr_bank] <= B_FULL;
          wr_idx           <= '0;
          wr_bank          <= ~wr_bank;
        end else begin
          bank_st[wr_bank] <= B_FILLING;
          wr_idx           <= wr_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_bitrev_buffer.sv
// Bench for frame_bitrev_buffer with FRAME_SIZE=8.
// A frame-level reference model predicts the output stream and the overflow pulses.
module tb_frame_bitrev_buffer;

  localparam int DW = 16;
  localparam int FS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;

  frame_bitrev_buffer #(.DATA_WIDTH(DW), .FRAME_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic last; } exp_t;

  int            tests = 0, fails = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] cur [FS];
  int            partial, held;
  int            ovf_cnt, xfer_cnt;
  bit            prev_stall, same_cycle_seen;
  logic [DW-1:0] prev_d;
  logic          prev_last;

  // 3-bit reversal: output k carries input index rev(k)
  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    partial = 0; held = 0; ovf_cnt = 0; xfer_cnt = 0;
    prev_stall = 0; same_cycle_seen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive at negedge, check outputs, advance model, check overflow
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy);
    bit   xf, rel, acc;
    exp_t e;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (!out_valid) begin
      tests++;
      if (out_data !== '0) begin
        fails++; $display("FAIL idle_data: got %0h exp 0", out_data);
      end
    end
    if (prev_stall) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_last) begin
        fails++;
        $display("FAIL stall_hold: got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b",
                 out_valid, out_data, out_last, prev_d, prev_last);
      end
    end
    xf  = (out_valid === 1'b1) && ordy;
    rel = 1'b0;
    if (xf) begin
      xfer_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL unexpected_xfer: got d=%0h exp none", out_data);
      end else begin
        e = exp_q.pop_front();
        rel = e.last;
        if (out_data !== e.d || out_last !== e.last) begin
          fails++;
          $display("FAIL out_sample: got d=%0h l=%0b exp d=%0h l=%0b", out_data, out_last, e.d, e.last);
        end
      end
    end
    prev_stall = (out_valid === 1'b1) && !ordy;
    prev_d = out_data; prev_last = out_last;
    acc = iv && (partial > 0 || (held - int'(rel)) < 2);
    if (iv && rel && partial == 0 && held == 2) same_cycle_seen = 1;
    @(posedge clk);
    #1;
    held -= int'(rel);
    if (acc) begin
      cur[partial] = d;
      partial++;
      if (partial == FS) begin
        for (int k = 0; k < FS; k++) begin
          e.d = cur[brev(k)]; e.last = (k == FS - 1);
          exp_q.push_back(e);
        end
        held++;
        partial = 0;
      end
    end
    tests++;
    if (overflow !== (iv && !acc)) begin
      fails++; $display("FAIL overflow: got %0b exp %0b", overflow, iv && !acc);
    end
    if (overflow === 1'b1) ovf_cnt++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL drain_timeout: got %0d pending exp 0", exp_q.size());
    end
    repeat (3) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hffff; out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b l=%0b o=%0b d=%0h exp all 0",
               out_valid, out_last, overflow, out_data);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int i = 0; i < FS; i++) step(1'b1, 16'(i), 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL latency_e0: got %0b exp 0", out_valid);
    end
    step(1'b0, '0, 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL latency_e1: got %0b exp 0", out_valid);
    end
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < FS; i++) begin
      tests++;
      if (out_valid !== 1'b1) begin
        fails++; $display("FAIL no_bubble: got %0b exp 1 at beat %0d", out_valid, i);
      end
      step(1'b0, '0, 1'b1);
    end
    tests++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL frame_end: got v=%0b pend=%0d exp v=0 pend=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_two_frames();
    do_reset();
    for (int i = 0; i < 2 * FS; i++) step(1'b1, 16'(i), 1'b1);
    drain(100);
    tests++;
    if (ovf_cnt != 0 || xfer_cnt != 2 * FS) begin
      fails++; $display("FAIL two_frames: got ovf=%0d xfer=%0d exp ovf=0 xfer=16", ovf_cnt, xfer_cnt);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    for (int i = 0; i < FS; i++) step(1'b1, 16'(16'h40 + i), 1'b1);
    while (exp_q.size() > 0 && n < 200) begin
      step(1'b0, '0, (n % 4 == 0) || (n % 4 == 3));
      n++;
    end
    drain(50);
    tests++;
    if (xfer_cnt != FS) begin
      fails++; $display("FAIL stall_count: got %0d exp 8", xfer_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 3 * FS; i++) step(1'b1, 16'(i), 1'b0);
    tests++;
    if (ovf_cnt != FS) begin
      fails++; $display("FAIL overflow_count: got %0d exp 8", ovf_cnt);
    end
    drain(100);
    tests++;
    if (xfer_cnt != 2 * FS) begin
      fails++; $display("FAIL overflow_xfers: got %0d exp 16", xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < FS + 5; i++) step(1'b1, 16'(i), 1'b1);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got v=%0b l=%0b o=%0b d=%0h exp all 0",
               out_valid, out_last, overflow, out_data);
    end
    in_valid = 1'b1; in_data = 16'hdead;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      fails++; $display("FAIL reset_hold: got v=%0b o=%0b d=%0h exp all 0", out_valid, overflow, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    model_clear();
    for (int i = 0; i < FS; i++) step(1'b1, 16'(100 + i), 1'b1);
    drain(50);
    tests++;
    if (xfer_cnt != FS) begin
      fails++; $display("FAIL post_reset_count: got %0d exp 8", xfer_cnt);
    end
  endtask

  task automatic test_same_cycle_release();
    do_reset();
    for (int i = 0; i < 2 * FS; i++) step(1'b1, 16'(i), 1'b0);
    for (int i = 0; i < FS + 4; i++) step(1'b1, 16'(16'h80 + i), 1'b1);
    tests++;
    if (!same_cycle_seen) begin
      fails++; $display("FAIL same_cycle_release: got 0 exp 1");
    end
    for (int i = 0; i < FS; i++) step(1'b1, 16'(16'h90 + i), 1'b1);
    drain(100);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
    drain(200);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_two_frames();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_same_cycle_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
